nibble_serial_addsub: RTL and testbench

- Multi-cycle WIDTH-bit adder/subtractor that processes one 4-bit slice per clock, least-significant nibble first.
- Sits directly upstream of the 4-bit carry-lookahead adder slice. It sequences operand nibbles into the slice and registers the inter-slice carry.
- It also assembles the full-width result and flags.
- Used where full-width parallel carry logic is too costly in area.

---
 rtl/nibble_serial_addsub.sv | 121 ++++++++++++
 tb/tb_nibble_serial_addsub.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor: one 4-bit carry slice per clock, LS nibble first.
// The result and flags are published together on completion; y never shows a partial sum.
module nibble_serial_addsub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [KW-1:0]    r_k;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_y;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [4:0]       w_sum;
  logic             w_c3;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_res_nxt;

  // One nibble of the ripple: the slice this block feeds, plus carry-into-bit-3 recovery
  always_comb begin
    w_a_nib   = r_a[{r_k, 2'b00} +: 4];
    w_b_nib   = r_b[{r_k, 2'b00} +: 4];
    w_sum     = 5'({1'b0, w_a_nib}) + 5'({1'b0, w_b_nib}) + 5'(r_carry);
    w_c3      = w_a_nib[3] ^ w_b_nib[3] ^ w_sum[3];
    w_last    = (r_k == KW'(N - 1));
    w_accept  = (r_state == S_IDLE) && start;
    w_res_nxt = r_res;
    w_res_nxt[{r_k, 2'b00} +: 4] = w_sum[3:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, per-nibble accumulation and completion publish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_y     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (w_state_nxt == S_RUN);
      if (w_accept) begin
        r_a     <= a;
        r_b     <= sub ? ~b : b;
        r_carry <= sub;
        r_k     <= '0;
      end else if (r_state == S_RUN) begin
        r_res   <= w_res_nxt;
        r_carry <= w_sum[4];
        r_k     <= r_k + KW'(1);
        if (w_last) begin
          r_y    <= w_res_nxt;
          r_cout <= w_sum[4];
          r_ovf  <= w_c3 ^ w_sum[4];
          r_zero <= (w_res_nxt == '0);
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign y        = r_y;
  assign cout     = r_cout;
  assign overflow = r_ovf;
  assign zero     = r_zero;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed bench for nibble_serial_addsub with a queue scoreboard checked on each done pulse.
module tb_nibble_serial_addsub;

  localparam int unsigned WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             c;
    logic             v;
    logic             z;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             cout;
  logic             overflow;
  logic             zero;

  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;
  int   cyc;
  exp_t sb[$];
  exp_t prev;

  nibble_serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .y(y), .cout(cout), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] fa, input logic [WIDTH-1:0] fb, input logic fs);
    exp_t r;
    logic [WIDTH:0] s;
    if (fs) s = {1'b0, fa} + {1'b0, ~fb} + (WIDTH+1)'(1);
    else    s = {1'b0, fa} + {1'b0, fb};
    r.y = s[WIDTH-1:0];
    r.c = s[WIDTH];
    if (fs) r.v = (fa[WIDTH-1] != fb[WIDTH-1]) && (r.y[WIDTH-1] != fa[WIDTH-1]);
    else    r.v = (fa[WIDTH-1] == fb[WIDTH-1]) && (r.y[WIDTH-1] != fa[WIDTH-1]);
    r.z = (r.y == '0);
    return r;
  endfunction

  // Scoreboard: each done pulse retires the oldest expected result
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      exp_t e;
      n_done++;
      check("done_busy_exclusive", 32'(busy), 32'd0);
      if (sb.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        check("y", 32'(y), 32'(e.y));
        check("cout", 32'(cout), 32'(e.c));
        check("overflow", 32'(overflow), 32'(e.v));
        check("zero", 32'(zero), 32'(e.z));
      end
    end
  end

  // Drive one start cycle; returns one negedge after the sampling edge
  task automatic do_start(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic ts);
    start = 1'b1; a = ta; b = tb; sub = ts;
    sb.push_back(model(ta, tb, ts));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) break;
    end
    if (done !== 1'b1) check("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic add: busy for 4 cycles, done 4 cycles after start
    do_start(16'h1234, 16'h0FFF, 1'b0);
    check("t1_busy0", 32'(busy), 32'd1);
    wait_done(cyc);
    check("t1_latency", 32'(cyc), 32'd4);
    check("t1_y_const", 32'(y), 32'h2233);
    @(negedge clk);

    do_start(16'hFFFF, 16'h0001, 1'b0); wait_done(cyc); @(negedge clk);
    do_start(16'h7FFF, 16'h0001, 1'b0); wait_done(cyc); @(negedge clk);
    do_start(16'h0005, 16'h0007, 1'b1); wait_done(cyc); @(negedge clk);
    do_start(16'h8000, 16'h0001, 1'b1); wait_done(cyc); @(negedge clk);
    do_start(16'h1234, 16'h1234, 1'b1); wait_done(cyc);
    check("t3_zero_const", 32'(zero), 32'd1);
    @(negedge clk);

    // Start while busy is ignored
    n_done = 0;
    do_start(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    start = 1'b1; a = 16'hAAAA; b = 16'h5555; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check("t4_latency", 32'(cyc), 32'd2);
    check("t4_y_const", 32'(y), 32'h3333);
    repeat (8) @(negedge clk);
    check("t4_single_done", 32'(n_done), 32'd1);

    // Back-to-back: restart in the done cycle
    do_start(16'h4321, 16'h1000, 1'b0);
    wait_done(cyc);
    prev = model(16'h4321, 16'h1000, 1'b0);
    do_start(16'h0001, 16'h0001, 1'b0);
    check("t5_busy", 32'(busy), 32'd1);
    check("t5_hold_a", 32'(y), 32'(prev.y));
    repeat (2) @(negedge clk);
    check("t5_hold_b", 32'(y), 32'(prev.y));
    wait_done(cyc);
    check("t5_latency", 32'(cyc), 32'd2);
    check("t5_y_const", 32'(y), 32'h0002);
    @(negedge clk);

    // Asynchronous reset mid-operation at k=2
    do_start(16'h00F0, 16'h0F00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_y", 32'(y), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    sb.delete();
    n_done = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_no_done", 32'(n_done), 32'd0);
    do_start(16'h0F0F, 16'h1010, 1'b0);
    wait_done(cyc);
    check("t6_latency", 32'(cyc), 32'd4);
    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
